// File: rtl/ula_arbitro.sv
// Two-requester front end sharing one 16-bit ALU (ula).
// Round-robin grant, one operation in flight, fixed IDLE -> EXEC -> RESP sequence.

module ula (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [2:0]  sel,
    output logic [15:0] result,
    output logic        cout
);
    logic        is_sub;
    logic [15:0] b_eff;
    logic [16:0] sum;

    always_comb begin
        is_sub = (sel == 3'b001);
        b_eff  = is_sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {16'd0, is_sub};
        cout   = sum[16];
        case (sel)
            3'b000:  result = sum[15:0];
            3'b001:  result = sum[15:0];
            3'b010:  result = a & b;
            3'b011:  result = a | b;
            3'b100:  result = ~(a & b);
            3'b101:  result = ~(a | b);
            3'b110:  result = a ^ b;
            default: result = sum[16] ? 16'h0000 : 16'h0001;
        endcase
    end
endmodule

module ula_arbitro (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [2:0]  req0_sel,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic [2:0]  req1_sel,
    output logic        req1_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_result,
    output logic        resp_cout,
    output logic        resp_zero,
    output logic        resp_id
);
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [2:0]  sel_q, sel_d;
    logic        id_q, id_d;
    logic [15:0] resp_result_q, resp_result_d;
    logic        resp_cout_q, resp_cout_d;
    logic        resp_zero_q, resp_zero_d;
    logic        resp_id_q, resp_id_d;

    logic        grant_valid, grant_id;
    logic [15:0] alu_result;
    logic        alu_cout;

    ula u_ula (
        .a      (a_q),
        .b      (b_q),
        .sel    (sel_q),
        .result (alu_result),
        .cout   (alu_cout)
    );

    // On a tie the requester that was not granted last wins.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid)
            grant_id = ~last_q;
        else
            grant_id = req1_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_q        <= 1'b1;
            a_q           <= 16'h0000;
            b_q           <= 16'h0000;
            sel_q         <= 3'b000;
            id_q          <= 1'b0;
            resp_result_q <= 16'h0000;
            resp_cout_q   <= 1'b0;
            resp_zero_q   <= 1'b0;
            resp_id_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            a_q           <= a_d;
            b_q           <= b_d;
            sel_q         <= sel_d;
            id_q          <= id_d;
            resp_result_q <= resp_result_d;
            resp_cout_q   <= resp_cout_d;
            resp_zero_q   <= resp_zero_d;
            resp_id_q     <= resp_id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        last_d        = last_q;
        a_d           = a_q;
        b_d           = b_q;
        sel_d         = sel_q;
        id_d          = id_q;
        resp_result_d = resp_result_q;
        resp_cout_d   = resp_cout_q;
        resp_zero_d   = resp_zero_q;
        resp_id_d     = resp_id_q;
        if (state_q == ST_IDLE && grant_valid) begin
            last_d = grant_id;
            id_d   = grant_id;
            a_d    = grant_id ? req1_a   : req0_a;
            b_d    = grant_id ? req1_b   : req0_b;
            sel_d  = grant_id ? req1_sel : req0_sel;
        end
        if (state_q == ST_EXEC) begin
            resp_result_d = alu_result;
            resp_cout_d   = alu_cout;
            resp_zero_d   = (alu_result == 16'h0000);
            resp_id_d     = id_q;
        end
    end

    always_comb begin
        req0_ready  = (state_q == ST_IDLE) && !rst && grant_valid && !grant_id;
        req1_ready  = (state_q == ST_IDLE) && !rst && grant_valid &&  grant_id;
        resp_valid  = (state_q == ST_RESP);
        resp_result = resp_result_q;
        resp_cout   = resp_cout_q;
        resp_zero   = resp_zero_q;
        resp_id     = resp_id_q;
    end
endmodule

// File: tb/tb_ula_arbitro.sv
// Scoreboard bench for ula_arbitro: expected responses are queued at acceptance
// and compared at the response handshake.

module tb_ula_arbitro;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_sel, req1_sel;
    logic        req0_ready, req1_ready;
    logic        resp_valid, resp_ready;
    logic [15:0] resp_result;
    logic        resp_cout, resp_zero, resp_id;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 0;
    logic [18:0] sb[$];
    bit          grant_log[$];
    int          grant_cyc[$];

    ula_arbitro dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_cout(resp_cout), .resp_zero(resp_zero), .resp_id(resp_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference ALU: packs {id, cout, zero, result}.
    function automatic logic [18:0] model(input bit id, input logic [15:0] a, input logic [15:0] b, input logic [2:0] sel);
        logic [16:0] add_s, sub_s;
        logic [15:0] res;
        logic        c;
        add_s = {1'b0, a} + {1'b0, b};
        sub_s = {1'b0, a} + {1'b0, ~b} + 17'd1;
        c = add_s[16];
        case (sel)
            3'd0: res = add_s[15:0];
            3'd1: begin res = sub_s[15:0]; c = sub_s[16]; end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = ~(a & b);
            3'd5: res = ~(a | b);
            3'd6: res = a ^ b;
            default: res = add_s[16] ? 16'h0000 : 16'h0001;
        endcase
        return {id, c, (res == 16'h0000), res};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rdy_in_rst", {30'd0, req0_ready, req1_ready}, 32'd0);
            sb.delete();
            lat = 0;
        end else begin
            if (lat == 1) begin
                checkOutput("lat_exec", {31'd0, resp_valid}, 32'd0);
                lat = 2;
            end else if (lat == 2) begin
                checkOutput("lat_resp", {31'd0, resp_valid}, 32'd1);
                lat = 0;
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0)
                    checkOutput("sb_unexpected", 32'd1, 32'd0);
                else
                    checkOutput("resp", {13'd0, resp_id, resp_cout, resp_zero, resp_result}, {13'd0, sb.pop_front()});
            end
            if (req0_valid && req0_ready && req1_valid && req1_ready)
                checkOutput("double_grant", 32'd1, 32'd0);
            if (req0_valid && req0_ready) begin
                sb.push_back(model(1'b0, req0_a, req0_b, req0_sel));
                grant_log.push_back(1'b0);
                grant_cyc.push_back(cyc);
                lat = 1;
            end else if (req1_valid && req1_ready) begin
                sb.push_back(model(1'b1, req1_a, req1_b, req1_sel));
                grant_log.push_back(1'b1);
                grant_cyc.push_back(cyc);
                lat = 1;
            end
        end
    end

    task automatic doReset(input bit hold_valid);
        rst = 1'b1;
        req0_valid = hold_valid;
        req1_valid = hold_valid;
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
    endtask

    // Presents one operation and returns 1ns after the accepting edge.
    task automatic applyStimulus(input bit id, input logic [15:0] a, input logic [15:0] b, input logic [2:0] sel);
        bit done = 1'b0;
        if (id) begin req1_a = a; req1_b = b; req1_sel = sel; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_sel = sel; req0_valid = 1'b1; end
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if ((id && req1_ready) || (!id && req0_ready)) done = 1'b1;
        end
        if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (id) begin req1_valid = 1'b0; req1_a = 16'($urandom); req1_b = 16'($urandom); end
        else    begin req0_valid = 1'b0; req0_a = 16'($urandom); req0_b = 16'($urandom); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit ok;
        req0_a = 0; req0_b = 0; req0_sel = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
        resp_ready = 1'b1;
        #1;

        // Reset with requests asserted, then idle for five cycles.
        doReset(1'b1);
        repeat (5) @(negedge clk);
        checkOutput("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("idle_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
        checkOutput("idle_result", {16'd0, resp_result}, 32'd0);
        checkOutput("idle_flags", {29'd0, resp_cout, resp_zero, resp_id}, 32'd0);
        @(posedge clk); #1;

        // Directed arithmetic cases.
        applyStimulus(1'b0, 16'h7FFF, 16'h0001, 3'd0);
        applyStimulus(1'b1, 16'h0005, 16'h0007, 3'd1);
        applyStimulus(1'b1, 16'h0007, 16'h0007, 3'd1);
        applyStimulus(1'b0, 16'hFFFF, 16'h0001, 3'd7);
        applyStimulus(1'b1, 16'h1000, 16'h0001, 3'd7);
        applyStimulus(1'b0, 16'hF0F0, 16'h0FF0, 3'd4);
        applyStimulus(1'b1, 16'hA5A5, 16'h5A5A, 3'd5);
        applyStimulus(1'b0, 16'h1234, 16'hFF00, 3'd6);
        repeat (3) @(posedge clk); #1;

        // Continuous contention after reset: alternating grants every 3 cycles.
        doReset(1'b0);
        grant_log.delete(); grant_cyc.delete();
        req0_a = 16'h1111; req0_b = 16'h2222; req0_sel = 3'd0;
        req1_a = 16'h00FF; req1_b = 16'h0F0F; req1_sel = 3'd6;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 40 && grant_log.size() < 4; i++) @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (grant_log.size() < 4) checkOutput("rr_timeout", grant_log.size(), 32'd4);
        else begin
            for (int i = 0; i < 4; i++) checkOutput("rr_order", {31'd0, grant_log[i]}, i % 2);
            for (int i = 1; i < 4; i++) checkOutput("rr_spacing", grant_cyc[i] - grant_cyc[i-1], 32'd3);
        end
        repeat (3) @(posedge clk); #1;

        // Back-pressure: response held while requester 0 is stalled.
        resp_ready = 1'b0;
        applyStimulus(1'b0, 16'hF0F0, 16'h0FF0, 3'd2);
        req0_a = 16'h1234; req0_b = 16'h4321; req0_sel = 3'd0; req0_valid = 1'b1;
        @(negedge clk);
        checkOutput("stall_exec_rdy", {31'd0, req0_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", {31'd0, resp_valid}, 32'd1);
            checkOutput("hold_result", {16'd0, resp_result}, 32'h00F0);
            checkOutput("hold_flags", {29'd0, resp_cout, resp_zero, resp_id}, 32'b100);
            checkOutput("hold_rdy", {31'd0, req0_ready}, 32'd0);
            req0_b = 16'($urandom);
        end
        req0_b = 16'h4321;
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        checkOutput("handshake_rdy", {31'd0, req0_ready}, 32'd0);
        @(negedge clk);
        checkOutput("post_hs_rdy", {31'd0, req0_ready}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Reset during EXEC discards the operation and restores priority to 0.
        applyStimulus(1'b0, 16'h0001, 16'h0002, 3'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) ok = 1'b0;
        end
        checkOutput("rst_discard", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        req0_a = 16'h0003; req0_b = 16'h0004; req0_sel = 3'd3;
        req1_a = 16'h0005; req1_b = 16'h0006; req1_sel = 3'd3;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_grant", {30'd0, req0_ready, req1_ready}, 32'b10);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Random operations on both requesters.
        for (int i = 0; i < 10; i++)
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("sb_drain", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
